// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: enable flags,
// default widths and the legacy two-state FSM encodings.
package regfile_mp_pkg;

  localparam bit ENABLED  = 1'b1;
  localparam bit DISABLED = 1'b0;
  localparam bit ZERO     = 1'b0;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [0:0] state_t;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/regfile_mp_if.sv
// Write/read port bundle between writeback/decode (master) and the
// register file (slave). Port k of a packed field sits at [k*W +: W].
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                  init_done;
  logic [NWR-1:0]        we;
  logic [NWR*ADDR_W-1:0] waddr;
  logic [NWR*DATA_W-1:0] wdata;
  logic [NRD-1:0]        re;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rvalid;

  modport master (
    output we, waddr, wdata, re, raddr,
    input  rdata, rvalid, init_done
  );

  modport slave (
    input  we, waddr, wdata, re, raddr,
    output rdata, rvalid, init_done
  );

endinterface

// File: rtl/regfile_bypass_sel.sv
// Per-read-port bypass selector: priority match of one read address
// against all effective write ports; the highest matching port wins.
module regfile_bypass_sel
  import regfile_mp_pkg::*;
#(
  parameter int NWR    = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [ADDR_W-1:0]     raddr,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  // Ascending scan so a later (higher-index) match overrides earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wen[j] && (waddr[j*ADDR_W +: ADDR_W] == raddr)) begin
        hit  = 1'b1;
        data = wdata[j*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NRD-read / NWR-write register file with write-to-read
// bypass, optional hardwired-zero entry 0 and a post-reset clear sweep.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DEPTH        = 32,
  parameter int NRD          = 2,
  parameter int NWR          = 2,
  parameter int ZERO_REG     = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  state_t                state;
  logic [ADDR_W-1:0]     clr_cnt;
  logic                  init_q;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [NWR-1:0]        wen;
  logic [NRD-1:0]        hit;
  logic [NRD*DATA_W-1:0] bdata;
  logic [NRD-1:0]        rvalid_q;
  logic [NRD*DATA_W-1:0] rdata_q;

  // An address is live if it is inside the array and not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Effective write enables: only in READY and only to live addresses.
  always_comb begin
    wen = '0;
    for (int unsigned j = 0; j < NWR; j++) begin
      wen[j] = (state == ST_READY) && bus.we[j] &&
               addr_ok(bus.waddr[j*ADDR_W +: ADDR_W]);
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_bypass_sel #(
      .NWR    (NWR),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_sel (
      .raddr (bus.raddr[i*ADDR_W +: ADDR_W]),
      .wen   (wen),
      .waddr (bus.waddr),
      .wdata (bus.wdata),
      .hit   (hit[i]),
      .data  (bdata[i*DATA_W +: DATA_W])
    );
  end

  // Clear sequencer: sweep every entry once, then sit in READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RST != 0) ? ST_INIT : ST_READY;
      clr_cnt <= '0;
      init_q  <= 1'b0;
    end else if (state == ST_INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == LAST) begin
        state  <= ST_READY;
        init_q <= 1'b1;
      end
    end else begin
      init_q <= 1'b1;
    end
  end

  // Storage: clear during INIT, otherwise apply writes in ascending port
  // order so the highest port's non-blocking update lands last.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[clr_cnt] <= '0;
      end else begin
        for (int unsigned j = 0; j < NWR; j++) begin
          if (wen[j]) begin
            mem[bus.waddr[j*ADDR_W +: ADDR_W]] <= bus.wdata[j*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Registered read ports: bypass first, then stored entry, dead addresses read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NRD; i++) begin
        rvalid_q[i] <= (state == ST_READY) && bus.re[i];
        if ((state == ST_READY) && bus.re[i]) begin
          if (hit[i]) begin
            rdata_q[i*DATA_W +: DATA_W] <= bdata[i*DATA_W +: DATA_W];
          end else if (addr_ok(bus.raddr[i*ADDR_W +: ADDR_W])) begin
            rdata_q[i*DATA_W +: DATA_W] <= mem[bus.raddr[i*ADDR_W +: ADDR_W]];
          end else begin
            rdata_q[i*DATA_W +: DATA_W] <= '0;
          end
        end
      end
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.init_done = init_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (32x32, 2R/2W, zero reg, clear on reset).
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.NRD(2), .NWR(2), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_mp #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .DEPTH        (D),
    .NRD          (2),
    .NWR          (2),
    .ZERO_REG     (1),
    .CLEAR_ON_RST (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we    = '0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.re    = '0;
    bus.raddr = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    bus.we[p]              = 1'b1;
    bus.waddr[p*AW +: AW]  = AW'(a);
    bus.wdata[p*DW +: DW]  = d;
  endtask

  task automatic rd(input int p, input int a);
    bus.re[p]             = 1'b1;
    bus.raddr[p*AW +: AW] = AW'(a);
  endtask

  function automatic logic [31:0] rdat(input int p);
    return bus.rdata[p*DW +: DW];
  endfunction

  // Called just after the reset edge with rst low: init_done must stay 0
  // for DEPTH-1 edges and rise on the DEPTH-th; reads stay dead throughout.
  task automatic wait_init(input string tag);
    for (int k = 1; k < D; k++) begin
      tick();
      if (k == 1 || k == D - 1) begin
        chk({tag, "_busy"}, {31'd0, bus.init_done}, 32'd0);
        chk({tag, "_rvalid0"}, {31'd0, bus.rvalid[0]}, 32'd0);
        chk({tag, "_rdata0"}, rdat(0), 32'd0);
      end
    end
    tick();
    chk({tag, "_done"}, {31'd0, bus.init_done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_init_done", {31'd0, bus.init_done}, 32'd0);
    chk("rst_rvalid", {30'd0, bus.rvalid}, 32'd0);
    chk("rst_rdata1", rdat(1), 32'd0);

    // Read requested throughout INIT is ignored, honoured once READY.
    rd(0, 3);
    wait_init("init0");
    chk("rv_at_done", {31'd0, bus.rvalid[0]}, 32'd0);
    tick();
    chk("rv_after_init", {31'd0, bus.rvalid[0]}, 32'd1);
    chk("rd_after_init", rdat(0), 32'd0);

    // Stored value is wiped by a reset-triggered sweep.
    idle(); wr(0, 3, 32'h1234); tick();
    idle(); rd(1, 3); tick();
    chk("r3_written", rdat(1), 32'h1234);
    chk("r3_rvalid", {31'd0, bus.rvalid[1]}, 32'd1);
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_rdata1", rdat(1), 32'd0);
    chk("rst2_rvalid", {30'd0, bus.rvalid}, 32'd0);
    wait_init("init1");
    for (int a = 0; a < D; a += 2) begin
      idle(); rd(0, a); rd(1, a + 1); tick();
      chk($sformatf("clr_r%0d", a), rdat(0), 32'd0);
      chk($sformatf("clr_r%0d", a + 1), rdat(1), 32'd0);
    end

    // Same-cycle write/read bypass.
    idle(); wr(0, 5, 32'hA5A5A5A5); rd(1, 5); tick();
    chk("bypass5", rdat(1), 32'hA5A5A5A5);
    idle(); rd(0, 5); tick();
    chk("stored5", rdat(0), 32'hA5A5A5A5);

    // Two ports hitting one address: higher port wins, bypassed and stored.
    idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7); tick();
    chk("bypass7", rdat(0), 32'h22);
    idle(); rd(1, 7); tick();
    chk("stored7", rdat(1), 32'h22);

    // Writes to entry 0 are dropped.
    idle(); wr(0, 0, 32'hFFFFFFFF); rd(1, 0); tick();
    chk("bypass_r0", rdat(1), 32'd0);
    idle(); rd(0, 0); tick();
    chk("stored_r0", rdat(0), 32'd0);

    // rdata holds while re is low, even as the entry changes.
    idle(); wr(0, 9, 32'h99); tick();
    idle(); rd(0, 9); tick();
    chk("r9_read", rdat(0), 32'h99);
    chk("r9_rvalid", {31'd0, bus.rvalid[0]}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      idle(); wr(1, 9, 32'h100 + 32'(k)); tick();
      chk($sformatf("hold%0d_rdata", k), rdat(0), 32'h99);
      chk($sformatf("hold%0d_rvalid", k), {31'd0, bus.rvalid[0]}, 32'd0);
    end
    idle(); rd(0, 9); rd(1, 9); tick();
    chk("r9_last_p0", rdat(0), 32'h102);
    chk("r9_last_p1", rdat(1), 32'h102);

    // Reset mid-sweep at clr_cnt==10 restarts a full DEPTH-cycle sweep.
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    repeat (10) tick();
    chk("mid_init_busy", {31'd0, bus.init_done}, 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    wait_init("init2");
    idle(); rd(0, 9); tick();
    chk("r9_cleared", rdat(0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
